// File: rtl/decoder_pkg.sv
// Shared types and decode helpers for the registered index decoder.
package decoder_pkg;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

   localparam logic MODE_ONEHOT = 1'b0;
   localparam logic MODE_THERM  = 1'b1;

   // One output bit of the decode; out-of-range indices force every bit low.
   function automatic logic decode_bit(input logic [31:0] addr, input logic mode,
                                       input logic en, input int unsigned idx,
                                       input int unsigned width);
      logic hit;
      if (mode == MODE_THERM) hit = (idx <= addr);
      else                    hit = (idx == addr);
      return en && hit && (addr < width);
   endfunction

   function automatic logic decode_err(input logic [31:0] addr, input int unsigned width);
      return addr >= width;
   endfunction

endpackage

// File: rtl/decoder_pipe_skid_buf.sv
// Two-entry skid buffer: head register drives the output, spare absorbs one beat of backpressure.
module skid_buf
   import decoder_pkg::*;
#(
   parameter int W = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [W-1:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [W-1:0] out_data,
   output skid_state_t state
);

   logic [W-1:0] spare;
   logic         push;
   logic         pop;

   // valid/ready: a beat moves on a channel at a rising edge where valid && ready;
   // ready here depends only on the registered state, never on in_valid.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_data <= '0;
         spare    <= '0;
      end else begin
         case (state)
            EMPTY: if (push) begin
               out_data <= in_data;
               state    <= ONE;
            end
            ONE: if (push && pop) begin
               out_data <= in_data;
            end else if (push) begin
               spare <= in_data;
               state <= FULL;
            end else if (pop) begin
               state <= EMPTY;
            end
            FULL: if (pop) begin
               out_data <= spare;
               state    <= ONE;
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/decoder_pipe.sv
// Registered one-hot / thermometer index decoder with valid/ready on both sides.
module decoder_pipe
   import decoder_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int OUT_W  = 8,
   parameter int REG_IN = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_y,
   output logic              out_err,
   output logic              busy
);

   localparam int DW = OUT_W + 1;

   logic             started;
   logic [OUT_W-1:0] dec_y;
   logic             dec_err;
   logic             s1_valid;
   logic             sk_valid;
   logic             sk_ready;
   logic [DW-1:0]    sk_in;
   logic [DW-1:0]    sk_out;
   skid_state_t      sk_state;

   // Holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) started <= 1'b0;
      else        started <= 1'b1;
   end

   for (genvar i = 0; i < OUT_W; i++) begin : g_dec
      assign dec_y[i] = decode_bit(32'(in_addr), in_mode, en, i, OUT_W);
   end
   assign dec_err = decode_err(32'(in_addr), OUT_W);

   if (REG_IN != 0) begin : g_reg_in
      logic          accept;
      logic [DW-1:0] s1_data;

      assign accept   = in_valid && in_ready;
      assign in_ready = started && (!s1_valid || sk_ready);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
         end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= {dec_err, dec_y};
         end else if (sk_ready) begin
            s1_valid <= 1'b0;
         end
      end

      assign sk_valid = s1_valid;
      assign sk_in    = s1_data;
   end else begin : g_no_reg
      assign in_ready = started && sk_ready;
      assign s1_valid = 1'b0;
      assign sk_valid = in_valid && started;
      assign sk_in    = {dec_err, dec_y};
   end

   skid_buf #(.W(DW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sk_valid),
      .in_ready  (sk_ready),
      .in_data   (sk_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (sk_out),
      .state     (sk_state)
   );

   assign out_y   = sk_out[OUT_W-1:0];
   assign out_err = sk_out[OUT_W];
   assign busy    = (sk_state != EMPTY) || s1_valid;

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: three configurations, directed literal cases and a randomized scoreboard run.
module tb_decoder_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int   sel = 0;
   logic d_valid = 1'b0, d_en = 1'b1, d_mode = 1'b0, d_ready = 1'b0;
   logic [2:0] d_addr = 3'd0;

   logic iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2, oe0, oe1, oe2, bz0, bz1, bz2;
   logic [7:0] y0, y1;
   logic [5:0] y2;
   logic cur_ir, cur_ov, cur_oe, cur_bz;
   logic [7:0] cur_y;

   assign iv0 = d_valid && (sel == 0);
   assign iv1 = d_valid && (sel == 1);
   assign iv2 = d_valid && (sel == 2);

   decoder_pipe #(.ADDR_W(3), .OUT_W(8), .REG_IN(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(d_en), .in_valid(iv0), .in_ready(ir0), .in_addr(d_addr),
      .in_mode(d_mode), .out_valid(ov0), .out_ready(d_ready), .out_y(y0), .out_err(oe0), .busy(bz0));
   decoder_pipe #(.ADDR_W(3), .OUT_W(8), .REG_IN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(d_en), .in_valid(iv1), .in_ready(ir1), .in_addr(d_addr),
      .in_mode(d_mode), .out_valid(ov1), .out_ready(d_ready), .out_y(y1), .out_err(oe1), .busy(bz1));
   decoder_pipe #(.ADDR_W(3), .OUT_W(6), .REG_IN(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(d_en), .in_valid(iv2), .in_ready(ir2), .in_addr(d_addr),
      .in_mode(d_mode), .out_valid(ov2), .out_ready(d_ready), .out_y(y2), .out_err(oe2), .busy(bz2));

   always_comb begin
      cur_ir = ir0; cur_ov = ov0; cur_oe = oe0; cur_bz = bz0; cur_y = y0;
      if (sel == 1) begin
         cur_ir = ir1; cur_ov = ov1; cur_oe = oe1; cur_bz = bz1; cur_y = y1;
      end else if (sel == 2) begin
         cur_ir = ir2; cur_ov = ov2; cur_oe = oe2; cur_bz = bz2; cur_y = {2'b00, y2};
      end
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", name, act, exp, sel, $time);
      end
   endtask

   // Reference decode from the rules: {err, y} padded to 8 bits of y.
   function automatic logic [8:0] ref_dec(input int addr, input int mode, input int en_v, input int w);
      if (addr >= w)  return 9'h100;
      if (en_v == 0)  return 9'h000;
      if (mode == 0)  return {1'b0, 8'(1 << addr)};
      return {1'b0, 8'((2 << addr) - 1)};
   endfunction

   function automatic int cur_w();
      return (sel == 2) ? 6 : 8;
   endfunction

   function automatic int cur_lat();
      return (sel == 1) ? 2 : 1;
   endfunction

   // Scoreboard entries: {accept cycle[31:0], err, y[7:0]}
   logic [40:0] exp_q[$];
   logic [40:0] got_q[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         logic exp_ov;
         int   sz;
         cyc++;
         sz = exp_q.size();
         exp_ov = (sz != 0) && ((cyc - int'(exp_q[0][40:9])) >= cur_lat());
         check("out_valid", cur_ov, exp_ov);
         check("busy", cur_bz, sz != 0);
         if (sel != 1)     check("in_ready", cur_ir, sz < 2);
         else if (sz == 0) check("in_ready_empty", cur_ir, 1'b1);
         else if (sz >= 3) check("in_ready_full", cur_ir, 1'b0);
         if (cur_ov && sz != 0) begin
            check("out_data", {cur_oe, cur_y}, exp_q[0][8:0]);
            if (d_ready) begin
               got_q.push_back({32'(cyc), cur_oe, cur_y});
               void'(exp_q.pop_front());
            end
         end
         if (d_valid && cur_ir)
            exp_q.push_back({32'(cyc), ref_dec(int'(d_addr), int'(d_mode), int'(d_en), cur_w())});
      end
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      d_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", cur_ov, 1'b0);
      check("rst_out_y", cur_y, 8'h00);
      check("rst_out_err", cur_oe, 1'b0);
      check("rst_busy", cur_bz, 1'b0);
      check("rst_in_ready", cur_ir, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      #1 check("in_ready_before_edge", cur_ir, 1'b0);
      @(posedge clk);
      #1 check("in_ready_after_edge", cur_ir, 1'b1);
   endtask

   // Called and returns at posedge+1; holds the request until it is accepted.
   task automatic send(input int addr, input int mode, input int en_v);
      int n = 0;
      d_valid = 1'b1;
      d_addr  = 3'(addr);
      d_mode  = 1'(mode);
      d_en    = 1'(en_v);
      forever begin
         @(negedge clk);
         if (cur_ir) break;
         n++;
         if (n > 50) begin
            check("send_timeout", 1'b0, 1'b1);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      d_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      d_valid = 1'b0;
      d_ready = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check("drain_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic run_random(input int n_tx);
      int acc = 0;
      int budget = n_tx * 8;
      bit hold = 1'b0;
      while (acc < n_tx && budget > 0) begin
         if (!hold) begin
            d_valid = ($urandom_range(0, 99) < 70);
            d_addr  = 3'($urandom_range(0, 7));
            d_mode  = 1'($urandom_range(0, 1));
            d_en    = ($urandom_range(0, 9) != 0);
         end
         d_ready = ($urandom_range(0, 99) < 60);
         @(negedge clk);
         if (d_valid && cur_ir) begin
            acc++;
            hold = 1'b0;
         end else begin
            hold = d_valid;
         end
         @(posedge clk); #1;
         budget--;
      end
      check("random_accepted", 32'(acc), 32'(n_tx));
      drain();
   endtask

   logic [7:0] oh_tab[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
   logic [8:0] th_tab[4] = '{9'h03F, 9'h001, 9'h000, 9'h000};
   logic [8:0] or_tab[5] = '{9'h100, 9'h100, 9'h100, 9'h100, 9'h03F};
   logic [7:0] bp_tab[3] = '{8'h02, 8'h04, 8'h08};

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // One-hot sweep, back to back, OUT_W=8 REG_IN=0
      sel = 0;
      apply_reset();
      d_ready = 1'b1;
      got_q.delete();
      for (int a = 0; a < 8; a++) send(a, 0, 1);
      drain();
      check("sweep_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         check("sweep_y", got_q[i][8:0], {1'b0, oh_tab[i]});
         check("sweep_rate", got_q[i][40:9], got_q[0][40:9] + 32'(i));
      end

      // Thermometer and enable
      got_q.delete();
      send(5, 1, 1); send(0, 1, 1); send(5, 0, 0); send(5, 1, 0);
      drain();
      check("therm_count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) check("therm_y", got_q[i][8:0], th_tab[i]);

      // Backpressure: two accepted, third blocked, head held
      got_q.delete();
      d_ready = 1'b0;
      send(1, 0, 1); send(2, 0, 1);
      d_valid = 1'b1; d_addr = 3'd3; d_mode = 1'b0; d_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", cur_ir, 1'b0);
         check("bp_hold_y", cur_y, 8'h02);
         @(posedge clk); #1;
      end
      d_ready = 1'b1;
      send(3, 0, 1);
      drain();
      check("bp_count", 32'(got_q.size()), 32'd3);
      for (int i = 0; i < 3 && i < got_q.size(); i++) check("bp_order", got_q[i][7:0], bp_tab[i]);

      // Reset while a result waits
      d_ready = 1'b0;
      send(3, 0, 1);
      @(negedge clk);
      check("pre_reset_valid", cur_ov, 1'b1);
      check("pre_reset_y", cur_y, 8'h08);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", cur_ov, 1'b0);
      check("async_rst_y", cur_y, 8'h00);
      apply_reset();
      d_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("no_stale_out", cur_ov, 1'b0);
      end
      @(posedge clk); #1;

      // Out-of-range with OUT_W=6
      sel = 2;
      apply_reset();
      d_ready = 1'b1;
      got_q.delete();
      send(6, 0, 1); send(7, 0, 1); send(6, 1, 1); send(7, 1, 0); send(5, 1, 1);
      drain();
      check("oor_count", 32'(got_q.size()), 32'd5);
      for (int i = 0; i < 5 && i < got_q.size(); i++) check("oor_y_err", got_q[i][8:0], or_tab[i]);

      // Randomized traffic on all three configurations
      sel = 0; apply_reset(); run_random(4000);
      sel = 1; apply_reset(); run_random(4000);
      sel = 2; apply_reset(); run_random(2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
